// File: rtl/sys_array_ctrl.sv
// Sequencer for a weight-stationary systolic array: latches a job,
// pulses weight-load, skews inputs in and deskews outputs into result.
module sys_array_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ARRAY_W_W  = 4,
   parameter int ARRAY_W_L  = 4,
   parameter int ARRAY_A_L  = 4,
   parameter int OUT_LAT    = ARRAY_W_L
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0] w_matrix,
   input  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0] a_matrix,
   output logic busy,
   output logic done,
   output logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] result,
   output logic arr_weights_load,
   output logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0] arr_weight_data,
   output logic [0:ARRAY_W_W-1][DATA_WIDTH-1:0] arr_input_data,
   input  logic [0:ARRAY_W_W-1][2*DATA_WIDTH-1:0] arr_output_data
);

   localparam int F_LAST = ARRAY_A_L + ARRAY_W_W - 2;
   localparam int G_LAST = F_LAST + OUT_LAT;
   localparam int GW = (G_LAST > 0) ? $clog2(G_LAST + 1) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t state, state_nx;
   logic [GW-1:0] g;
   logic [31:0] gx;
   logic accept;
   logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0] a_lat;

   assign gx = 32'(g);
   assign accept = (state == IDLE) && start;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy = 1'b0;
      done = 1'b0;
      arr_weights_load = 1'b0;
      unique case (state)
         IDLE: if (start) state_nx = LOAD;
         LOAD: begin
            busy = 1'b1;
            arr_weights_load = 1'b1;
            state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (g == GW'(G_LAST)) state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // g sits at 0 outside RUN so the first RUN cycle is step 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         g <= '0;
      else if (state == RUN && g != GW'(G_LAST))
         g <= g + 1'b1;
      else
         g <= '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arr_weight_data <= '0;
         a_lat <= '0;
         result <= '0;
      end else if (accept) begin
         arr_weight_data <= w_matrix;
         a_lat <= a_matrix;
         result <= '0;
      end else if (state == RUN) begin
         for (int t = 0; t < ARRAY_W_W; t++)
            for (int c = 0; c < ARRAY_A_L; c++)
               if (gx == 32'(c + t + OUT_LAT))
                  result[t][c] <= arr_output_data[t];
      end
   end

   // row r sees column g-r; matched as g == c+r to stay unsigned
   always_comb begin
      arr_input_data = '0;
      if (state == RUN && gx <= 32'(F_LAST))
         for (int r = 0; r < ARRAY_W_W; r++)
            for (int c = 0; c < ARRAY_A_L; c++)
               if (gx == 32'(c + r))
                  arr_input_data[r] = a_lat[r][c];
   end

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Bench for sys_array_ctrl: delay-line array stub, directed jobs,
// abort, back-to-back and a reduced-size instance.
module tb_sys_array_ctrl;

   localparam int G_LAST = 10;

   typedef logic [0:3][0:3][7:0] mat_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic start;
   mat_t w_m, a_m;
   logic busy, done, wload;
   logic [0:3][0:3][15:0] result;
   mat_t wdata;
   logic [0:3][7:0] indata;
   logic [0:3][15:0] outdata;
   logic [0:3][7:0] dly [4];

   sys_array_ctrl dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .w_matrix(w_m), .a_matrix(a_m),
      .busy(busy), .done(done), .result(result),
      .arr_weights_load(wload), .arr_weight_data(wdata),
      .arr_input_data(indata), .arr_output_data(outdata)
   );

   always_ff @(posedge clk) begin
      dly[0] <= indata;
      for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
   end

   always_comb begin
      outdata = '0;
      for (int t = 0; t < 4; t++)
         outdata[t] = {8'h00, dly[3][t]} + 16'(t << 8);
   end

   logic start6;
   logic [0:1][0:2][7:0] w6;
   logic [0:1][0:0][7:0] a6;
   logic busy6, done6, wload6;
   logic [0:1][0:0][15:0] res6;
   logic [0:1][0:2][7:0] wd6;
   logic [0:1][7:0] in6;
   logic [0:1][15:0] out6;
   logic [0:1][7:0] dly6 [3];

   sys_array_ctrl #(
      .DATA_WIDTH(8), .ARRAY_W_W(2), .ARRAY_W_L(3),
      .ARRAY_A_L(1), .OUT_LAT(3)
   ) u6 (
      .clk(clk), .reset_n(reset_n), .start(start6),
      .w_matrix(w6), .a_matrix(a6),
      .busy(busy6), .done(done6), .result(res6),
      .arr_weights_load(wload6), .arr_weight_data(wd6),
      .arr_input_data(in6), .arr_output_data(out6)
   );

   always_ff @(posedge clk) begin
      dly6[0] <= in6;
      for (int i = 1; i < 3; i++) dly6[i] <= dly6[i-1];
   end

   always_comb begin
      out6 = '0;
      for (int t = 0; t < 2; t++)
         out6[t] = {8'h00, dly6[2][t]} + 16'(t << 8);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic mat_t mk_a();
      mat_t m;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m[r][c] = 8'(16 * r + c);
      return m;
   endfunction

   function automatic mat_t mk_w();
      mat_t m;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m[r][c] = 8'(4 * r + c + 1);
      return m;
   endfunction

   task automatic chk_res(input mat_t a, input string tag);
      for (int t = 0; t < 4; t++)
         for (int c = 0; c < 4; c++)
            chk(tag, result[t][c], 16'(t << 8) + {8'h00, a[t][c]});
   endtask

   // called at a negedge in IDLE; returns at a negedge in IDLE
   task automatic run_job(input mat_t a, input bit probe, input bit poke);
      int done_cyc;
      int n_done;
      mat_t w_exp;
      done_cyc = -1;
      n_done = 0;
      w_exp = mk_w();
      w_m = w_exp;
      a_m = a;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= G_LAST + 6; cyc++) begin
         chk("busy", busy, 32'(cyc <= G_LAST + 2));
         chk("wload", wload, 32'(cyc == 1));
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (cyc == 3) chk("wts", wdata == w_exp, 1);
         if (probe && cyc == 5)
            chk("feed_g3", indata, {a[0][3], a[1][2], a[2][1], a[3][0]});
         if (probe && cyc == 9) chk("feed_g7", indata, 0);
         if (poke && cyc == 7) begin
            start = 1'b1;
            a_m = ~a;
            w_m = ~w_exp;
         end
         if (poke && cyc == 8) start = 1'b0;
         @(negedge clk);
      end
      chk("done_cyc", done_cyc, G_LAST + 3);
      chk("done_cnt", n_done, 1);
      chk("wts_hold", wdata == w_exp, 1);
   endtask

   initial begin
      mat_t a;
      mat_t ai;
      int d1;
      int d2;
      int d6;
      start = 1'b0;
      start6 = 1'b0;
      w_m = '0;
      a_m = '0;
      w6 = '0;
      a6 = '0;
      a = mk_a();
      ai = ~a;
      repeat (5) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_res", result != '0, 0);
      chk("rst_wload", wload, 0);
      chk("rst_in", indata, 0);
      chk("rst_wd", wdata != '0, 0);
      reset_n = 1'b1;
      @(negedge clk);

      run_job(a, 1'b1, 1'b0);
      chk_res(a, "res_job1");
      chk("res32", result[3][2], 16'h0332);

      run_job(a, 1'b0, 1'b1);
      chk_res(a, "res_poke");

      w_m = mk_w();
      a_m = ai;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_abort_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_res", result != '0, 0);
      chk("abort_wd", wdata != '0, 0);
      chk("abort_in", indata, 0);
      chk("abort_wload", wload, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_job(a, 1'b0, 1'b0);
      chk_res(a, "res_after_abort");

      d1 = -1;
      d2 = -1;
      a_m = a;
      start = 1'b1;
      @(negedge clk);
      for (int cyc = 1; cyc <= 2 * G_LAST + 8; cyc++) begin
         if (cyc == 2) a_m = ai;
         if (done && d1 < 0) d1 = cyc;
         else if (done && d2 < 0) d2 = cyc;
         if (cyc == G_LAST + 4) begin
            chk("b2b_gap_busy", busy, 0);
            chk("b2b_hold", result[3][2], 16'h0332);
         end
         if (cyc == G_LAST + 5) begin
            chk("b2b_load", wload, 1);
            chk("b2b_clear", result != '0, 0);
         end
         if (cyc == 2 * G_LAST + 7) start = 1'b0;
         @(negedge clk);
      end
      chk("b2b_d1", d1, G_LAST + 3);
      chk("b2b_d2", d2, 2 * G_LAST + 7);
      chk_res(ai, "res_job2");

      d6 = -1;
      w6 = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      a6 = {8'h5A, 8'hC3};
      start6 = 1'b1;
      @(negedge clk);
      start6 = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         if (cyc == 1) chk("p6_wload", wload6, 1);
         if (cyc == 2) chk("p6_feed_g0", in6, 16'h5A00);
         if (cyc == 3) chk("p6_feed_g1", in6, 16'h00C3);
         if (done6 && d6 < 0) d6 = cyc;
         @(negedge clk);
      end
      chk("p6_done_cyc", d6, 7);
      chk("p6_res0", res6[0][0], 16'h005A);
      chk("p6_res1", res6[1][0], 16'h01C3);
      chk("p6_wd", wd6 == w6, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
